// File: rtl/led_mode_sequencer.sv
// rtl/led_mode_sequencer.sv - button-driven LED pattern scheduler with debounced mode select.
// Optional auto-advance of the mode every AUTO_TICKS blink ticks when LED_AUTO_CYCLE_EN is defined.
module led_mode_sequencer #(
    parameter int unsigned TICK_DIV   = 32'd3_000_000,
    parameter int unsigned DEBOUNCE   = 32'd120_000,
    parameter int unsigned AUTO_TICKS = 32'd16
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       BTN,
    output logic       LED1,
    output logic       LED2,
    output logic [1:0] MODE
);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_BLINK = 2'd1,
        MODE_ALT   = 2'd2,
        MODE_ON    = 2'd3
    } mode_e;

    localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);
    localparam logic [23:0] DEB_LAST  = 24'(DEBOUNCE - 1);

    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        stable_q, stable_d;
    logic        stable_dly_q, stable_dly_d;
    logic [23:0] deb_cnt_q, deb_cnt_d;
    logic [31:0] tick_cnt_q, tick_cnt_d;
    logic        phase_q, phase_d;
    mode_e       mode_q, mode_d;
    logic        led1_q, led1_d;
    logic        led2_q, led2_d;

    logic press;
    logic tick;
    logic auto_adv;
    logic advance;

    // A level change is accepted only after DEBOUNCE consecutive mismatching cycles.
    always_comb begin
        sync1_d      = BTN;
        sync2_d      = sync1_q;
        stable_dly_d = stable_q;
        stable_d     = stable_q;
        deb_cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                stable_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 24'd1;
            end
        end
    end

    assign press = stable_q & ~stable_dly_q;
    assign tick  = (tick_cnt_q == TICK_LAST);

`ifdef LED_AUTO_CYCLE_EN
    localparam int AUTO_W = (AUTO_TICKS > 1) ? $clog2(AUTO_TICKS) : 1;
    localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_TICKS - 1);

    logic [AUTO_W-1:0] auto_cnt_q, auto_cnt_d;

    always_comb begin
        auto_cnt_d = auto_cnt_q;
        auto_adv   = 1'b0;
        if (press) begin
            auto_cnt_d = '0;
        end else if (tick) begin
            if (auto_cnt_q == AUTO_LAST) begin
                auto_adv   = 1'b1;
                auto_cnt_d = '0;
            end else begin
                auto_cnt_d = auto_cnt_q + AUTO_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            auto_cnt_q <= '0;
        end else begin
            auto_cnt_q <= auto_cnt_d;
        end
    end
`else
    assign auto_adv = 1'b0;
`endif

    // A press and an auto-advance landing together still produce one step.
    assign advance = press | auto_adv;

    always_comb begin
        tick_cnt_d = tick_cnt_q + 32'd1;
        phase_d    = phase_q;
        mode_d     = mode_q;
        if (advance) begin
            tick_cnt_d = '0;
            phase_d    = 1'b0;
            case (mode_q)
                MODE_OFF:   mode_d = MODE_BLINK;
                MODE_BLINK: mode_d = MODE_ALT;
                MODE_ALT:   mode_d = MODE_ON;
                default:    mode_d = MODE_OFF;
            endcase
        end else if (tick) begin
            tick_cnt_d = '0;
            phase_d    = ~phase_q;
        end
    end

    always_comb begin
        led1_d = 1'b0;
        led2_d = 1'b0;
        case (mode_q)
            MODE_OFF: begin
                led1_d = 1'b0;
                led2_d = 1'b0;
            end
            MODE_BLINK: begin
                led1_d = phase_q;
                led2_d = phase_q;
            end
            MODE_ALT: begin
                led1_d = phase_q;
                led2_d = ~phase_q;
            end
            default: begin
                led1_d = 1'b1;
                led2_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            deb_cnt_q    <= '0;
            tick_cnt_q   <= '0;
            phase_q      <= 1'b0;
            mode_q       <= MODE_OFF;
            led1_q       <= 1'b0;
            led2_q       <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            deb_cnt_q    <= deb_cnt_d;
            tick_cnt_q   <= tick_cnt_d;
            phase_q      <= phase_d;
            mode_q       <= mode_d;
            led1_q       <= led1_d;
            led2_q       <= led2_d;
        end
    end

    assign LED1 = led1_q;
    assign LED2 = led2_q;
    assign MODE = mode_q;

endmodule

// File: tb/tb_led_mode_sequencer.sv
// tb/tb_led_mode_sequencer.sv - self-checking bench for led_mode_sequencer.
// Honours LED_AUTO_CYCLE_EN to match the build under test.
module tb_led_mode_sequencer;

    localparam int TD = 4;
    localparam int DB = 3;
    localparam int AT = 2;

    logic       CLK   = 1'b0;
    logic       RST_N = 1'b0;
    logic       BTN   = 1'b0;
    logic       LED1;
    logic       LED2;
    logic [1:0] MODE;

    int tests = 0;
    int fails = 0;

    // Reference model: edges counted since reset, edge of last mode advance,
    // and the raw button level captured at every edge.
    int   n;
    int   e;
    int   mode_m;
    bit   stable_m;
    bit   press_m;
    bit   led1_m;
    bit   led2_m;
    bit   smp[$];

    led_mode_sequencer #(
        .TICK_DIV  (TD),
        .DEBOUNCE  (DB),
        .AUTO_TICKS(AT)
    ) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .BTN  (BTN),
        .LED1 (LED1),
        .LED2 (LED2),
        .MODE (MODE)
    );

    always #5 CLK = ~CLK;

    function automatic bit syn(input int j);
        return (j >= 3) ? smp[j-2] : 1'b0;
    endfunction

    task automatic model_reset();
        n = 0; e = 0; mode_m = 0;
        stable_m = 1'b0; press_m = 1'b0;
        led1_m = 1'b0; led2_m = 1'b0;
        smp.delete();
        smp.push_back(1'b0);
    endtask

    task automatic model_edge(input bit b);
        int ph;
        bit adv;
        bit all_mis;
        n++;
        smp.push_back(b);
        ph = ((n - 1 - e) / TD) % 2;
        case (mode_m)
            0:       begin led1_m = 1'b0;  led2_m = 1'b0;   end
            1:       begin led1_m = ph[0]; led2_m = ph[0];  end
            2:       begin led1_m = ph[0]; led2_m = !ph[0]; end
            default: begin led1_m = 1'b1;  led2_m = 1'b1;   end
        endcase
        adv = press_m;
`ifdef LED_AUTO_CYCLE_EN
        if (n - e == TD * AT) adv = 1'b1;
`endif
        if (adv) begin
            mode_m = (mode_m + 1) % 4;
            e = n;
        end
        all_mis = (n - DB + 1 >= 1);
        for (int j = n - DB + 1; j <= n; j++)
            if (j >= 1 && syn(j) == stable_m) all_mis = 1'b0;
        press_m = 1'b0;
        if (all_mis) begin
            stable_m = !stable_m;
            press_m  = stable_m;
        end
    endtask

    task automatic step(input bit b);
        BTN = b;
        @(posedge CLK);
        #1;
        model_edge(b);
    endtask

    task automatic do_reset();
        BTN = 1'b0;
        RST_N = 1'b0;
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        BTN = 1'b0;
        RST_N = 1'b0;
        repeat (5) begin
            @(posedge CLK);
            #1;
            tests++;
            if ({MODE, LED1, LED2} !== 4'b0000) begin
                fails++;
                $display("FAIL reset_hold: got mode=%0d leds=%b%b expected mode=0 leds=00", MODE, LED1, LED2);
            end
        end
        RST_N = 1'b1;
        model_reset();
        for (int i = 0; i < 100; i++) begin
            step(1'b0);
            tests++;
            if ({MODE, LED1, LED2} !== {2'(mode_m), led1_m, led2_m}) begin
                fails++;
                $display("FAIL reset_idle: edge %0d got mode=%0d leds=%b%b expected mode=%0d leds=%b%b",
                         n, MODE, LED1, LED2, mode_m, led1_m, led2_m);
            end
        end
    endtask

    task automatic test_clean_press();
        int chg;
        logic [1:0] prev;
        chg = 0;
        do_reset();
        prev = MODE;
        for (int i = 1; i <= 40; i++) begin
            step(i <= 20);
            tests++;
            if ({MODE, LED1, LED2} !== {2'(mode_m), led1_m, led2_m}) begin
                fails++;
                $display("FAIL clean_press: edge %0d got mode=%0d leds=%b%b expected mode=%0d leds=%b%b",
                         i, MODE, LED1, LED2, mode_m, led1_m, led2_m);
            end
            if (MODE !== prev) chg++;
            prev = MODE;
`ifndef LED_AUTO_CYCLE_EN
            if (i == 5 || i == 6) begin
                tests++;
                if (MODE !== 2'(i - 5)) begin
                    fails++;
                    $display("FAIL press_latency: edge %0d got mode=%0d expected %0d", i, MODE, i - 5);
                end
            end
`endif
        end
`ifndef LED_AUTO_CYCLE_EN
        tests++;
        if (chg != 1) begin
            fails++;
            $display("FAIL single_press: got %0d mode changes expected 1", chg);
        end
`endif
    endtask

    task automatic test_bounce();
        bit pat [0:6];
        pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 22; i++) begin
            step(i < 7 ? pat[i] : 1'b0);
            tests++;
            if ({MODE, LED1, LED2} !== {2'(mode_m), led1_m, led2_m}) begin
                fails++;
                $display("FAIL bounce: edge %0d got mode=%0d leds=%b%b expected mode=%0d leds=%b%b",
                         n, MODE, LED1, LED2, mode_m, led1_m, led2_m);
            end
`ifndef LED_AUTO_CYCLE_EN
            tests++;
            if (MODE !== 2'd0) begin
                fails++;
                $display("FAIL bounce_mode: edge %0d got mode=%0d expected 0", n, MODE);
            end
`endif
        end
    endtask

    task automatic test_blink();
        bit first;
        logic [1:0] prev;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            step(i < 10);
            tests++;
            if ({MODE, LED1, LED2} !== {2'(mode_m), led1_m, led2_m}) begin
                fails++;
                $display("FAIL blink: edge %0d got mode=%0d leds=%b%b expected mode=%0d leds=%b%b",
                         n, MODE, LED1, LED2, mode_m, led1_m, led2_m);
            end
`ifndef LED_AUTO_CYCLE_EN
            if (i >= 7) begin
                tests++;
                if (LED1 !== LED2) begin
                    fails++;
                    $display("FAIL blink_equal: edge %0d got leds=%b%b expected equal", n, LED1, LED2);
                end
            end
`endif
        end
        first = 1'b1;
        prev = MODE;
        for (int i = 0; i < 30; i++) begin
            step(i < 10);
            tests++;
            if ({MODE, LED1, LED2} !== {2'(mode_m), led1_m, led2_m}) begin
                fails++;
                $display("FAIL alt: edge %0d got mode=%0d leds=%b%b expected mode=%0d leds=%b%b",
                         n, MODE, LED1, LED2, mode_m, led1_m, led2_m);
            end
`ifndef LED_AUTO_CYCLE_EN
            if (MODE == 2'd2 && prev == 2'd2) begin
                tests++;
                if (LED2 !== !LED1 || (first && {LED1, LED2} !== 2'b01)) begin
                    fails++;
                    $display("FAIL alt_pattern: edge %0d got leds=%b%b first=%0d", n, LED1, LED2, first);
                end
                first = 1'b0;
            end
`endif
            prev = MODE;
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 20; i++) begin
                step(i < 10);
                tests++;
                if ({MODE, LED1, LED2} !== {2'(mode_m), led1_m, led2_m}) begin
                    fails++;
                    $display("FAIL wrap: edge %0d got mode=%0d leds=%b%b expected mode=%0d leds=%b%b",
                             n, MODE, LED1, LED2, mode_m, led1_m, led2_m);
                end
            end
`ifndef LED_AUTO_CYCLE_EN
            tests++;
            if (MODE !== 2'((k + 1) % 4)) begin
                fails++;
                $display("FAIL wrap_seq: press %0d got mode=%0d expected %0d", k + 1, MODE, (k + 1) % 4);
            end
`endif
        end
`ifndef LED_AUTO_CYCLE_EN
        tests++;
        if ({LED1, LED2} !== 2'b00) begin
            fails++;
            $display("FAIL wrap_leds: got leds=%b%b expected 00", LED1, LED2);
        end
`endif
    endtask

    task automatic test_collision();
        do_reset();
        for (int i = 1; i <= 28; i++) begin
            step(i >= 7 && i < 17);
            tests++;
            if ({MODE, LED1, LED2} !== {2'(mode_m), led1_m, led2_m}) begin
                fails++;
                $display("FAIL collision: edge %0d got mode=%0d leds=%b%b expected mode=%0d leds=%b%b",
                         n, MODE, LED1, LED2, mode_m, led1_m, led2_m);
            end
`ifndef LED_AUTO_CYCLE_EN
            if (i >= 13 && i <= 17) begin
                tests++;
                if (LED1 !== (i == 17)) begin
                    fails++;
                    $display("FAIL collision_phase: edge %0d got led1=%b expected %b", i, LED1, i == 17);
                end
            end
`endif
        end
    endtask

    task automatic test_random();
        bit lvl;
        int len;
        do_reset();
        lvl = 1'b0;
        for (int seg = 0; seg < 60; seg++) begin
            len = (seg % 3 == 0) ? $urandom_range(1, 3) : $urandom_range(2, 14);
            lvl = !lvl;
            for (int i = 0; i < len; i++) begin
                step(lvl);
                tests++;
                if ({MODE, LED1, LED2} !== {2'(mode_m), led1_m, led2_m}) begin
                    fails++;
                    $display("FAIL random: edge %0d got mode=%0d leds=%b%b expected mode=%0d leds=%b%b",
                             n, MODE, LED1, LED2, mode_m, led1_m, led2_m);
                end
            end
        end
    endtask

    task automatic test_auto();
        do_reset();
`ifdef LED_AUTO_CYCLE_EN
        for (int i = 0; i < 40; i++) begin
            step(1'b0);
            tests++;
            if ({MODE, LED1, LED2} !== {2'(mode_m), led1_m, led2_m}) begin
                fails++;
                $display("FAIL auto: edge %0d got mode=%0d leds=%b%b expected mode=%0d leds=%b%b",
                         n, MODE, LED1, LED2, mode_m, led1_m, led2_m);
            end
            if (n % 8 == 0) begin
                tests++;
                if (MODE !== 2'((n / 8) % 4)) begin
                    fails++;
                    $display("FAIL auto_step: edge %0d got mode=%0d expected %0d", n, MODE, (n / 8) % 4);
                end
            end
        end
`else
        for (int i = 0; i < 1000; i++) begin
            step(1'b0);
            tests++;
            if (MODE !== 2'd0) begin
                fails++;
                $display("FAIL no_auto: edge %0d got mode=%0d expected 0", n, MODE);
            end
        end
`endif
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(i < 8);
            tests++;
            if ({MODE, LED1, LED2} !== {2'(mode_m), led1_m, led2_m}) begin
                fails++;
                $display("FAIL pre_async: edge %0d got mode=%0d leds=%b%b expected mode=%0d leds=%b%b",
                         n, MODE, LED1, LED2, mode_m, led1_m, led2_m);
            end
        end
        #2;
        RST_N = 1'b0;
        #1;
        tests++;
        if ({MODE, LED1, LED2} !== 4'b0000) begin
            fails++;
            $display("FAIL async_reset: got mode=%0d leds=%b%b expected mode=0 leds=00", MODE, LED1, LED2);
        end
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        model_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b0);
            tests++;
            if ({MODE, LED1, LED2} !== {2'(mode_m), led1_m, led2_m}) begin
                fails++;
                $display("FAIL post_async: edge %0d got mode=%0d leds=%b%b expected mode=%0d leds=%b%b",
                         n, MODE, LED1, LED2, mode_m, led1_m, led2_m);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_blink();
        test_wrap();
        test_collision();
        test_random();
        test_auto();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
